inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be as listed in REQ-003 to REQ-013.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 imem_req_val  out  1  instruction-memory read request valid.
REQ-006 imem_req_addr  out  32  word-aligned fetch address; equals the PC.
REQ-007 imem_req_rdy  in  1  memory accepts the request when it is high together with imem_req_val.
REQ-008 imem_resp_val  in  1  read data valid.
REQ-009 imem_resp_data  in  32  fetched instruction word.
REQ-010 inst_val  out  1  instruction is presented to the control decoder.
REQ-011 inst_data  out  32  registered instruction word; drives the decoder's instMem_data input.
REQ-012 inst_pc  out  32  PC of inst_data.
REQ-013 inst_rdy / pc_src  in  1 / 1  decoder consumes the instruction; branch-taken select (0 = PC+4, 1 = branch target).

Function
REQ-014 The FSM SHALL have exactly four states: RST, REQ, WAIT and HOLD.
REQ-015 RST SHALL go to REQ on the first clock edge after rst deasserts; outputs SHALL be held at their reset values while in RST.
REQ-016 In REQ: imem_req_val=1, imem_req_addr=pc; the FSM SHALL go to WAIT on imem_req_val&&imem_req_rdy and stay in REQ otherwise.
REQ-017 In WAIT, imem_req_val SHALL be 0; on imem_resp_val the block SHALL load ir<=imem_resp_data and go to HOLD.
REQ-018 imem_resp_val SHALL be ignored in RST, REQ and HOLD; the block SHALL allow at most one outstanding request.
REQ-019 In HOLD: inst_val=1, inst_data=ir, inst_pc=pc.
REQ-020 In HOLD, on inst_rdy the block SHALL set pc<=next_pc and go to REQ; without inst_rdy it SHALL stay in HOLD with inst_data stable.
REQ-021 next_pc SHALL equal pc_src ? pc+4+{sext(ir[15:0]),2'b00} : pc+4, using 32-bit modulo arithmetic; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-022 pc_src SHALL be sampled only in the cycle in which inst_val&&inst_rdy is true.
REQ-023 pc[1:0] SHALL always be 2'b00; RESET_PC[1:0] SHALL be 0, and the low bits of the branch target are zero by construction.
REQ-024 Minimum latency SHALL be 3 cycles per instruction (REQ→WAIT→HOLD) with zero-wait memory and inst_rdy held high.
REQ-025 inst_val SHALL be 0 in all states other than HOLD.

Reset
REQ-026 rst SHALL, asynchronously and from any state, force: state=RST, pc=RESET_PC, ir=0, inst_val=0, inst_data=0, inst_pc=RESET_PC, imem_req_val=0.
REQ-027 A reset asserted during WAIT SHALL abandon the pending response; the memory drops in-flight reads on rst.

Configuration
REQ-028 When INST_FETCH_CNT_EN is defined, the block SHALL add output inst_count[31:0], reset to 0, incremented on each inst_val&&inst_rdy and wrapping at 2^32.
REQ-029 When INST_FETCH_CNT_EN is not defined, the port and the counter logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package proc_pkg SHALL hold the fetch state enum (RST, REQ, WAIT, HOLD), the pc_src encodings (PC_SRC_PC4=0, PC_SRC_BR=1) and the opcode constants (LW, SW, ADDIU, BNE) that are shared with control.
REQ-031 The combinational next-PC adder/mux SHALL be a sub-module named inst_fetch_pc_next; the FSM and the registers SHALL stay in inst_fetch.

Verification
REQ-032 Reset release, RESET_PC=0, rdy/resp zero-wait, inst_rdy=1 -> imem_req_addr sequence 0,4,8; inst_val high every 3rd cycle.
REQ-033 Fetch with ir=BNE with imm=16'hFFFF at pc=0x10, pc_src=1 on accept -> next imem_req_addr=0x10.
REQ-034 imem_req_rdy held low 5 cycles -> imem_req_val and imem_req_addr stable throughout; WAIT entered only after rdy is high.
REQ-035 inst_rdy low 4 cycles in HOLD -> inst_data/inst_pc unchanged, no new request; pc_src toggling while inst_rdy=0 has no effect.
REQ-036 rst asserted mid-WAIT, then a stray imem_resp_val after release -> stray response ignored, ir=0, first request to RESET_PC.
REQ-037 RESET_PC=32'hFFFF_FFFC, pc_src=0 -> second fetch address 0; with INST_FETCH_CNT_EN, inst_count=2 after two accepts.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM states, pc_src encodings, opcodes
// shared with control, and the branch-offset helper used by the next-PC logic.
package proc_pkg;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic PC_SRC_PC4 = 1'b0;
  localparam logic PC_SRC_BR  = 1'b1;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] ADDIU = 6'b001001;
  localparam logic [5:0] BNE   = 6'b000101;

  // Word offset: sign-extended immediate scaled by 4, so targets stay word aligned.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch bundle: instruction-memory request/response plus decoder hand-off.
// Carries inst_count only when INST_FETCH_CNT_EN is defined.
interface inst_fetch_if;
  logic        imem_req_val;
  logic [31:0] imem_req_addr;
  logic        imem_req_rdy;
  logic        imem_resp_val;
  logic [31:0] imem_resp_data;
  logic        inst_val;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_rdy;
  logic        pc_src;
`ifdef INST_FETCH_CNT_EN
  logic [31:0] inst_count;
`endif

  modport master (
    output imem_req_val, imem_req_addr,
    input  imem_req_rdy, imem_resp_val, imem_resp_data,
    output inst_val, inst_data, inst_pc,
    input  inst_rdy, pc_src
`ifdef INST_FETCH_CNT_EN
    , output inst_count
`endif
  );

  modport slave (
    input  imem_req_val, imem_req_addr,
    output imem_req_rdy, imem_resp_val, imem_resp_data,
    input  inst_val, inst_data, inst_pc,
    output inst_rdy, pc_src
`ifdef INST_FETCH_CNT_EN
    , input inst_count
`endif
  );
endinterface

// File: rtl/inst_fetch_pc_next.sv
// Combinational next-PC: sequential PC+4 or taken-branch target, modulo 2^32.
module inst_fetch_pc_next
  import proc_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [15:0] imm_i,
  input  logic        pc_src_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pcPlus4;

  assign pcPlus4   = pc_i + 32'd4;
  assign next_pc_o = (pc_src_i == PC_SRC_BR) ? (pcPlus4 + branch_offset(imm_i)) : pcPlus4;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch FSM (RST/REQ/WAIT/HOLD) with one outstanding memory read.
// Optional retired-instruction counter on bus.inst_count with INST_FETCH_CNT_EN.
module inst_fetch
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  nextPc;
  logic         accept;

  assign accept = (state_q == HOLD) && bus.inst_rdy;

  inst_fetch_pc_next u_pc_next (
    .pc_i      (pc_q),
    .imm_i     (ir_q[15:0]),
    .pc_src_i  (bus.pc_src),
    .next_pc_o (nextPc)
  );

  // Responses are only honoured in WAIT, which keeps a single read in flight.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      RST:  state_d = REQ;
      REQ:  if (bus.imem_req_rdy) state_d = WAIT;
      WAIT: if (bus.imem_resp_val) begin
        ir_d    = bus.imem_resp_data;
        state_d = HOLD;
      end
      HOLD: if (accept) begin
        pc_d    = nextPc;
        state_d = REQ;
      end
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.imem_req_val  = (state_q == REQ);
  assign bus.imem_req_addr = pc_q;
  assign bus.inst_val      = (state_q == HOLD);
  assign bus.inst_data     = ir_q;
  assign bus.inst_pc       = pc_q;

`ifdef INST_FETCH_CNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.inst_count = count_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table on a RESET_PC=0 instance,
// plus hand-written reset-in-WAIT and PC-wrap sequences on a second instance.
module tb_inst_fetch;
  import proc_pkg::*;

  typedef struct {
    logic        rdy;
    logic        respVal;
    logic [31:0] respData;
    logic        instRdy;
    logic        pcSrc;
    logic        expReqVal;
    logic [31:0] expAddr;
    logic        expInstVal;
    logic [31:0] expData;
    logic [31:0] expPc;
  } vec_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs[$];

  localparam logic [31:0] D0   = {LW,    5'd0, 5'd1, 16'h0000};
  localparam logic [31:0] D1   = {SW,    5'd0, 5'd2, 16'h0004};
  localparam logic [31:0] D2   = {ADDIU, 5'd0, 5'd3, 16'h0007};
  localparam logic [31:0] D3   = {BNE,   5'd0, 5'd0, 16'h0008};
  localparam logic [31:0] BN   = {BNE,   5'd1, 5'd0, 16'hFFFF};
  localparam logic [31:0] D4   = 32'hAAAA_0040;
  localparam logic [31:0] JUNK = 32'h5555_5555;

  inst_fetch_if if0 ();
  inst_fetch_if if1 ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] d, logic ir, logic ps,
                              logic eRv, logic [31:0] eA, logic eIv, logic [31:0] eD,
                              logic [31:0] eP);
    vec_t v;
    v.rdy = rdy; v.respVal = rv; v.respData = d; v.instRdy = ir; v.pcSrc = ps;
    v.expReqVal = eRv; v.expAddr = eA; v.expInstVal = eIv; v.expData = eD; v.expPc = eP;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if0.imem_req_rdy   = v.rdy;
    if0.imem_resp_val  = v.respVal;
    if0.imem_resp_data = v.respData;
    if0.inst_rdy       = v.instRdy;
    if0.pc_src         = v.pcSrc;
  endtask

  task automatic checkDut0(input string tag, input logic eRv, input logic [31:0] eA,
                           input logic eIv, input logic [31:0] eD, input logic [31:0] eP);
    checkOutput({tag, ".req_val"},  {31'd0, if0.imem_req_val}, {31'd0, eRv});
    checkOutput({tag, ".req_addr"}, if0.imem_req_addr, eA);
    checkOutput({tag, ".inst_val"}, {31'd0, if0.inst_val}, {31'd0, eIv});
    checkOutput({tag, ".inst_data"}, if0.inst_data, eD);
    checkOutput({tag, ".inst_pc"},  if0.inst_pc, eP);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    applyStimulus(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
    if1.imem_req_rdy   = 1'b1;
    if1.imem_resp_val  = 1'b1;
    if1.imem_resp_data = {BNE, 5'd0, 5'd0, 16'h0010};
    if1.inst_rdy       = 1'b1;
    if1.pc_src         = 1'b0;

    // Zero-wait fetches 0,4,8,C then BNE at 0x10 (imm -1) branches back to 0x10.
    vecs.push_back(mk(1,1,D0,1,0,  1,32'h00,0,32'h0,32'h00));
    vecs.push_back(mk(1,1,D0,1,0,  0,32'h00,0,32'h0,32'h00));
    vecs.push_back(mk(1,1,D0,1,0,  0,32'h00,1,D0,32'h00));
    vecs.push_back(mk(1,1,D1,1,0,  1,32'h04,0,D0,32'h04));
    vecs.push_back(mk(1,1,D1,1,0,  0,32'h04,0,D0,32'h04));
    vecs.push_back(mk(1,1,D1,1,0,  0,32'h04,1,D1,32'h04));
    vecs.push_back(mk(1,1,D2,1,0,  1,32'h08,0,D1,32'h08));
    vecs.push_back(mk(1,1,D2,1,0,  0,32'h08,0,D1,32'h08));
    vecs.push_back(mk(1,1,D2,1,0,  0,32'h08,1,D2,32'h08));
    vecs.push_back(mk(1,1,D3,1,0,  1,32'h0C,0,D2,32'h0C));
    vecs.push_back(mk(1,1,D3,1,0,  0,32'h0C,0,D2,32'h0C));
    vecs.push_back(mk(1,1,D3,1,0,  0,32'h0C,1,D3,32'h0C));
    vecs.push_back(mk(1,1,BN,1,0,  1,32'h10,0,D3,32'h10));
    vecs.push_back(mk(1,1,BN,1,0,  0,32'h10,0,D3,32'h10));
    vecs.push_back(mk(1,1,BN,1,1,  0,32'h10,1,BN,32'h10));
    vecs.push_back(mk(1,1,D4,1,1,  1,32'h10,0,BN,32'h10));
    // Memory stalls five cycles; responses offered in REQ must be ignored.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,1,JUNK,1,1, 1,32'h10,0,BN,32'h10));
    vecs.push_back(mk(1,0,JUNK,1,0,  0,32'h10,0,BN,32'h10));
    vecs.push_back(mk(1,1,D4,0,1,    0,32'h10,1,D4,32'h10));
    // Decoder stalls four cycles with pc_src toggling; only the accept cycle counts.
    vecs.push_back(mk(1,1,JUNK,0,1,  0,32'h10,1,D4,32'h10));
    vecs.push_back(mk(1,1,JUNK,0,0,  0,32'h10,1,D4,32'h10));
    vecs.push_back(mk(1,1,JUNK,0,1,  0,32'h10,1,D4,32'h10));
    vecs.push_back(mk(1,1,JUNK,0,0,  0,32'h10,1,D4,32'h10));
    vecs.push_back(mk(1,1,JUNK,1,0,  1,32'h14,0,D4,32'h14));
    vecs.push_back(mk(1,0,JUNK,1,0,  0,32'h14,0,D4,32'h14));

    tick();
    tick();
    checkDut0("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    checkOutput("dut1.reset.req_addr", if1.imem_req_addr, 32'hFFFF_FFFC);
    checkOutput("dut1.reset.req_val", {31'd0, if1.imem_req_val}, 32'd0);
`ifdef INST_FETCH_CNT_EN
    checkOutput("dut1.reset.count", if1.inst_count, 32'd0);
`endif
    rst0 = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkDut0($sformatf("v%0d", i), vecs[i].expReqVal, vecs[i].expAddr,
                vecs[i].expInstVal, vecs[i].expData, vecs[i].expPc);
    end

    // Reset asserted mid-WAIT, then a stray response right after release.
    #3;
    rst0 = 1'b1;
    if0.imem_resp_val  = 1'b1;
    if0.imem_resp_data = JUNK;
    #1;
    checkDut0("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    checkDut0("rst_held", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst0 = 1'b0;
    if0.imem_resp_data = 32'hDEAD_BEEF;
    if0.imem_req_rdy   = 1'b1;
    if0.inst_rdy       = 1'b1;
    tick();
    checkDut0("post_rst_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    if0.imem_resp_val = 1'b0;
    tick();
    checkDut0("post_rst_wait", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    checkDut0("post_rst_wait2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    if0.imem_resp_val  = 1'b1;
    if0.imem_resp_data = D0;
    if0.inst_rdy       = 1'b0;
    tick();
    checkDut0("post_rst_hold", 1'b0, 32'h0, 1'b1, D0, 32'h0);

    // Second instance: PC wraps from FFFF_FFFC to 0.
    rst1 = 1'b0;
    tick();
    checkOutput("wrap.first_addr", if1.imem_req_addr, 32'hFFFF_FFFC);
    checkOutput("wrap.first_val", {31'd0, if1.imem_req_val}, 32'd1);
    tick();
    tick();
    checkOutput("wrap.hold_pc", if1.inst_pc, 32'hFFFF_FFFC);
    checkOutput("wrap.hold_val", {31'd0, if1.inst_val}, 32'd1);
    tick();
    checkOutput("wrap.second_addr", if1.imem_req_addr, 32'h0);
    checkOutput("wrap.second_val", {31'd0, if1.imem_req_val}, 32'd1);
    tick();
    tick();
    tick();
    checkOutput("wrap.third_addr", if1.imem_req_addr, 32'h4);
`ifdef INST_FETCH_CNT_EN
    checkOutput("wrap.count", if1.inst_count, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
